spi_cs_sequencer: RTL
=====================

# spi_cs_sequencer

Transaction controller that sits directly upstream of `SPI_Master`. It buffers outgoing bytes in a small TX FIFO and frames multi-byte transfers with an active-low chip select. It feeds bytes to the master one at a time through the master's TX_DV/TX_Ready handshake and returns every received byte to the host. This turns the single-byte master into a usable peripheral port for the SoC bus bridge.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, at least 2.
- `MAX_BYTES`, 16: largest transaction length; count width is `CW = $clog2(MAX_BYTES+1)`.
- `CS_LEAD_CLKS`, 2: i_Clk cycles from CS assert to the first byte, and from the last RX byte to CS deassert.
- `CS_IDLE_CLKS`, 4: minimum i_Clk cycles CS stays high between transactions.

Ports:
- `i_Clk`, in, 1: system clock.
- `i_Rst`, in, 1: asynchronous, active-high reset.
- `i_TX_Byte`, in, 8: byte to push into the FIFO.
- `i_TX_DV`, in, 1: push strobe, one byte per cycle.
- `o_TX_Full`, out, 1: FIFO full; a push while full is dropped.
- `i_Start`, in, 1: start pulse; samples `i_Count`.
- `i_Count`, in, CW: number of bytes in the transaction.
- `o_Busy`, out, 1: high from accepted Start until Done.
- `o_Done`, out, 1: one-cycle pulse at the end of a transaction.
- `o_RX_Byte`, out, 8: received byte.
- `o_RX_DV`, out, 1: one-cycle valid for `o_RX_Byte`.
- `o_SPI_CS_n`, out, 1: chip select, active low.
- `o_M_TX_Byte`, out, 8: byte to `SPI_Master`.
- `o_M_TX_DV`, out, 1: byte valid to `SPI_Master`, one-cycle pulse.
- `i_M_TX_Ready`, in, 1: master ready.
- `i_M_RX_DV`, in, 1: master RX valid.
- `i_M_RX_Byte`, in, 8: master RX byte.

## Operation
- States are IDLE, LEAD, SEND, WAIT_RX, TRAIL and GAP.
- **IDLE:**
  - CS is high.
  - `i_Start` with `i_Count` != 0 latches the count into `remaining`, drives CS low, sets Busy and moves to LEAD.
  - `i_Start` with `i_Count` = 0 is ignored. Values above `MAX_BYTES` saturate to `MAX_BYTES`.
- **LEAD:** counts `CS_LEAD_CLKS` cycles, then moves to SEND.
- **SEND:**
  - When the FIFO is not empty and `i_M_TX_Ready` = 1, pop the head byte onto `o_M_TX_Byte`, pulse `o_M_TX_DV` for one cycle and move to WAIT_RX.
  - When the FIFO is empty, stall in SEND with CS held low (underrun stretches the frame; it is not an error).
- **WAIT_RX:**
  - On `i_M_RX_DV`, register the byte to `o_RX_Byte`/`o_RX_DV` and decrement `remaining`.
  - If the result is 0, go to TRAIL; otherwise go to SEND.
- **TRAIL:** counts `CS_LEAD_CLKS` cycles, then drives CS high and moves to GAP.
- **GAP:** counts `CS_IDLE_CLKS` cycles, then pulses `o_Done`, clears Busy and returns to IDLE.
- `i_Start` while Busy is ignored.
- **FIFO:**
  - Circular buffer with separate read and write pointers plus an occupancy count of `$clog2(FIFO_DEPTH)+1` bits; pointers wrap modulo `FIFO_DEPTH`.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - A push when full is dropped and the write pointer is not advanced.
  - A push when full is honoured if a pop happens in the same cycle.
  - Pushes are accepted in every state, including while a transaction runs.
  - Bytes left over after Done remain queued for the next transaction.

## Timing
- **Reset values:** CS_n = 1, all other outputs 0, FIFO empty, state IDLE, counters 0. Reset mid-transaction raises CS asynchronously and discards FIFO contents.
- Start to CS low: 1 cycle, since CS_n is registered.
- CS low to first `o_M_TX_DV`: `CS_LEAD_CLKS` + 1 cycles, assuming the FIFO is not empty and the master is ready.
- `i_M_RX_DV` to `o_RX_DV`: 1 cycle.
- Next `o_M_TX_DV`: no earlier than 1 cycle after `i_M_RX_DV`.
- Last `i_M_RX_DV` to CS high: `CS_LEAD_CLKS` + 1 cycles.
- CS high to `o_Done`: `CS_IDLE_CLKS` cycles. `o_Busy` falls with `o_Done`.
- `o_M_TX_DV` never asserts while CS is high or while `i_M_TX_Ready` = 0.

## Structure
- Shared package `spi_pkg` holds the state encoding (3-bit localparams) and the `CS_LEAD_CLKS`/`CS_IDLE_CLKS` defaults, so `SPI_Master` benches can reuse them.
- One sub-module, `spi_tx_fifo`: parameterised synchronous FIFO with push, pop, full, empty and data ports. The sequencer FSM and timers live in the top module.

## Test plan
- **Three-byte transaction:** push 0xAB, 0x56, 0x3C; Start with Count = 3; model echoes MISO bytes 0x11, 0x22, 0x33. Required response:
  - `o_M_TX_Byte` sequence is AB, 56, 3C.
  - `o_RX_Byte` sequence is 11, 22, 33.
  - CS is low for the whole frame.
  - Done appears `CS_IDLE_CLKS` cycles after CS rises.
- **Underrun:** Start with Count = 2 and FIFO empty; push 0x5A after 20 cycles, then 0xA5. Required response: CS stays low, no TX_DV appears before the push, and both bytes are sent in order.
- **FIFO full:** push 9 bytes 0x00..0x08 with depth 8. Required response: `o_TX_Full` = 1 after the 8th push, 0x08 is dropped, and a Count = 8 transaction sends 0x00..0x07.
- **Ignored Starts:** Start with Count = 0 leaves Busy = 0 and CS = 1. A Start while Busy does not change `remaining`.
- **Reset mid-transaction:** assert `i_Rst` during WAIT_RX of byte 2 of 4. Required response: CS_n = 1 immediately, FIFO empty, and no Done pulse.
- **Simultaneous push and pop at full:** with the FIFO full, a push in the same cycle as a TX pop is accepted, occupancy stays 8, and order is preserved across pointer wrap.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI chip-select sequencer and its neighbours:
// state encoding and default chip-select timing.
package spi_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LEAD    = 3'd1;
   localparam logic [2:0] ST_SEND    = 3'd2;
   localparam logic [2:0] ST_WAIT_RX = 3'd3;
   localparam logic [2:0] ST_TRAIL   = 3'd4;
   localparam logic [2:0] ST_GAP     = 3'd5;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      LEAD    = ST_LEAD,
      SEND    = ST_SEND,
      WAIT_RX = ST_WAIT_RX,
      TRAIL   = ST_TRAIL,
      GAP     = ST_GAP
   } state_t;

   localparam int CS_LEAD_CLKS_DEF = 2;
   localparam int CS_IDLE_CLKS_DEF = 4;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Circular TX byte buffer. A push while full is only taken when a pop
// frees a slot in the same cycle.
module spi_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         if (push_ok && !pop_ok)      count <= count + (PW+1)'(1);
         else if (pop_ok && !push_ok) count <= count - (PW+1)'(1);
      end
   end

endmodule

// File: rtl/spi_cs_sequencer.sv
// Frames multi-byte SPI transfers with an active-low chip select and feeds
// queued TX bytes one at a time to a single-byte SPI master.
//
// state   | meaning
// IDLE    | CS high, waiting for a Start with a non-zero count
// LEAD    | CS low, settling before the first byte
// SEND    | waiting for a queued byte and a ready master, then launching it
// WAIT_RX | byte in flight, waiting for the master's RX valid
// TRAIL   | last byte done, CS still low for the hold time
// GAP     | CS high, enforcing the minimum idle time before Done
module spi_cs_sequencer
   import spi_pkg::*;
#(
   parameter  int FIFO_DEPTH   = 8,
   parameter  int MAX_BYTES    = 16,
   parameter  int CS_LEAD_CLKS = CS_LEAD_CLKS_DEF,
   parameter  int CS_IDLE_CLKS = CS_IDLE_CLKS_DEF,
   localparam int CW           = $clog2(MAX_BYTES+1)
) (
   input  logic          i_Clk,
   input  logic          i_Rst,
   input  logic [7:0]    i_TX_Byte,
   input  logic          i_TX_DV,
   output logic          o_TX_Full,
   input  logic          i_Start,
   input  logic [CW-1:0] i_Count,
   output logic          o_Busy,
   output logic          o_Done,
   output logic [7:0]    o_RX_Byte,
   output logic          o_RX_DV,
   output logic          o_SPI_CS_n,
   output logic [7:0]    o_M_TX_Byte,
   output logic          o_M_TX_DV,
   input  logic          i_M_TX_Ready,
   input  logic          i_M_RX_DV,
   input  logic [7:0]    i_M_RX_Byte
);

   localparam int TMAX = max_int(CS_LEAD_CLKS, CS_IDLE_CLKS);
   localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
   localparam logic [TW-1:0] LEAD_LOAD = TW'(CS_LEAD_CLKS - 1);
   localparam logic [TW-1:0] GAP_LOAD  = TW'(CS_IDLE_CLKS - 1);

   state_t        state, state_nxt;
   logic          cs_n, cs_n_nxt;
   logic          busy, busy_nxt;
   logic          done, done_nxt;
   logic          m_dv, m_dv_nxt;
   logic          rx_dv, rx_dv_nxt;
   logic [7:0]    m_byte, m_byte_nxt;
   logic [7:0]    rx_byte, rx_byte_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [CW-1:0] remaining, rem_nxt;
   logic [CW-1:0] count_sat;
   logic [CW-1:0] rem_dec;
   logic          pop;
   logic          fifo_empty;
   logic [7:0]    fifo_head;

   spi_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk     (i_Clk),
      .rst     (i_Rst),
      .push    (i_TX_DV),
      .wr_data (i_TX_Byte),
      .pop     (pop),
      .rd_data (fifo_head),
      .full    (o_TX_Full),
      .empty   (fifo_empty)
   );

   assign count_sat = (i_Count > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : i_Count;
   assign rem_dec   = remaining - CW'(1);

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state     <= IDLE;
         cs_n      <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         m_dv      <= 1'b0;
         rx_dv     <= 1'b0;
         m_byte    <= '0;
         rx_byte   <= '0;
         timer     <= '0;
         remaining <= '0;
      end else begin
         state     <= state_nxt;
         cs_n      <= cs_n_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         m_dv      <= m_dv_nxt;
         rx_dv     <= rx_dv_nxt;
         m_byte    <= m_byte_nxt;
         rx_byte   <= rx_byte_nxt;
         timer     <= timer_nxt;
         remaining <= rem_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cs_n_nxt    = cs_n;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      m_dv_nxt    = 1'b0;
      rx_dv_nxt   = 1'b0;
      m_byte_nxt  = m_byte;
      rx_byte_nxt = rx_byte;
      timer_nxt   = timer;
      rem_nxt     = remaining;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            if (i_Start && (i_Count != '0)) begin
               rem_nxt   = count_sat;
               cs_n_nxt  = 1'b0;
               busy_nxt  = 1'b1;
               timer_nxt = LEAD_LOAD;
               state_nxt = LEAD;
            end
         end
         LEAD: begin
            if (timer == '0) state_nxt = SEND;
            else             timer_nxt = timer - TW'(1);
         end
         SEND: begin
            // An empty FIFO simply stretches the frame until a byte arrives.
            if (!fifo_empty && i_M_TX_Ready) begin
               pop        = 1'b1;
               m_byte_nxt = fifo_head;
               m_dv_nxt   = 1'b1;
               state_nxt  = WAIT_RX;
            end
         end
         WAIT_RX: begin
            if (i_M_RX_DV) begin
               rx_byte_nxt = i_M_RX_Byte;
               rx_dv_nxt   = 1'b1;
               rem_nxt     = rem_dec;
               if (rem_dec == '0) begin
                  timer_nxt = LEAD_LOAD;
                  state_nxt = TRAIL;
               end else begin
                  state_nxt = SEND;
               end
            end
         end
         TRAIL: begin
            if (timer == '0) begin
               cs_n_nxt  = 1'b1;
               timer_nxt = GAP_LOAD;
               state_nxt = GAP;
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
         GAP: begin
            if (timer == '0) begin
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign o_SPI_CS_n  = cs_n;
   assign o_Busy      = busy;
   assign o_Done      = done;
   assign o_M_TX_DV   = m_dv;
   assign o_M_TX_Byte = m_byte;
   assign o_RX_DV     = rx_dv;
   assign o_RX_Byte   = rx_byte;

endmodule
